// File: rtl/if_neuron_layer.sv
// if_neuron_layer: layer of integrate-and-fire neurons sharing one spike input vector,
// with a writable weight matrix and a refractory period after each firing.
module if_neuron_layer #(
    parameter int NUM_INPUTS   = 4,
    parameter int NUM_NEURONS  = 1,
    parameter int WEIGHT_WIDTH = 8,
    parameter int POT_WIDTH    = 16,
    parameter int THRESHOLD    = 64,
    parameter int REFRAC       = 5
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [NUM_INPUTS-1:0]                                 spike_in,
    input  logic                                                  in_valid,
    input  logic                                                  wr_en,
    input  logic [(NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1)-1:0] wr_neuron,
    input  logic [(NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1)-1:0]   wr_input,
    input  logic [WEIGHT_WIDTH-1:0]                               wr_data,
    input  logic [NUM_NEURONS-1:0]                                neuron_rst,
    output logic [NUM_NEURONS-1:0]                                spike_out,
    output logic [NUM_NEURONS-1:0]                                refrac_busy
);
    localparam int SUM_W = $clog2(NUM_INPUTS * (2 ** WEIGHT_WIDTH - 1) + 1);
    localparam int P_W   = (POT_WIDTH > SUM_W ? POT_WIDTH : SUM_W) + 1;
    localparam int CW    = REFRAC > 0 ? $clog2(REFRAC + 1) : 1;
    localparam logic [P_W-1:0] THR  = P_W'(THRESHOLD);
    localparam logic [P_W-1:0] PMAX = P_W'({POT_WIDTH{1'b1}});

    typedef enum logic {INTEGRATE, REFRACTORY} state_t;

    logic [WEIGHT_WIDTH-1:0] w   [NUM_NEURONS][NUM_INPUTS];
    logic [POT_WIDTH-1:0]    pot [NUM_NEURONS];
    logic [CW-1:0]           cnt [NUM_NEURONS];
    state_t                  st  [NUM_NEURONS];
    logic [SUM_W-1:0]        sum [NUM_NEURONS];
    logic [P_W-1:0]          p   [NUM_NEURONS];

    // p is wide enough that potential plus a full-weight sum can never wrap
    always_comb begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            sum[n] = '0;
            for (int j = 0; j < NUM_INPUTS; j++)
                sum[n] = sum[n] + (spike_in[j] ? SUM_W'(w[n][j]) : '0);
            p[n] = P_W'(pot[n]) + P_W'(sum[n]);
            refrac_busy[n] = st[n] == REFRACTORY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spike_out <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                pot[n] <= '0;
                cnt[n] <= '0;
                st[n]  <= INTEGRATE;
                for (int j = 0; j < NUM_INPUTS; j++)
                    w[n][j] <= '0;
            end
        end else begin
            spike_out <= '0;
            if (wr_en && int'(wr_neuron) < NUM_NEURONS && int'(wr_input) < NUM_INPUTS)
                w[wr_neuron][wr_input] <= wr_data;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                // a controller clear freezes the state machine for this edge
                if (neuron_rst[n]) begin
                    pot[n] <= '0;
                end else if (in_valid) begin
                    if (st[n] == REFRACTORY) begin
                        pot[n] <= '0;
                        cnt[n] <= cnt[n] - CW'(1);
                        st[n]  <= cnt[n] == CW'(1) ? INTEGRATE : REFRACTORY;
                    end else if (p[n] >= THR) begin
                        pot[n]       <= '0;
                        spike_out[n] <= 1'b1;
                        st[n]        <= REFRAC > 0 ? REFRACTORY : INTEGRATE;
                        cnt[n]       <= CW'(REFRAC);
                    end else begin
                        pot[n] <= p[n] > PMAX ? '1 : p[n][POT_WIDTH-1:0];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_if_neuron_layer.sv
// tb_if_neuron_layer: scoreboard bench; dut_a uses THRESHOLD=10, dut_b THRESHOLD=65535.
module tb_if_neuron_layer;
    logic clk = 0;
    logic rst = 0;
    logic [3:0] spike_in = '0;
    logic va = 0, vb = 0, wea = 0, web = 0;
    logic wr_neuron = 0;
    logic [1:0] wr_input = '0;
    logic [7:0] wr_data = '0;
    logic [1:0] nr_a = '0;
    logic [1:0] nr_b = '0;
    logic [1:0] spa, bza, spb, bzb;
    int chk = 0, err = 0, n = 0;

    typedef struct {
        logic b;
        logic [1:0] sp, bz;
        logic [15:0] p0, p1;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    if_neuron_layer #(.NUM_INPUTS(4), .NUM_NEURONS(2), .WEIGHT_WIDTH(8), .POT_WIDTH(16),
                      .THRESHOLD(10), .REFRAC(2)) dut_a (
        .clk(clk), .rst(rst), .spike_in(spike_in), .in_valid(va), .wr_en(wea),
        .wr_neuron(wr_neuron), .wr_input(wr_input), .wr_data(wr_data),
        .neuron_rst(nr_a), .spike_out(spa), .refrac_busy(bza));

    if_neuron_layer #(.NUM_INPUTS(4), .NUM_NEURONS(2), .WEIGHT_WIDTH(8), .POT_WIDTH(16),
                      .THRESHOLD(65535), .REFRAC(2)) dut_b (
        .clk(clk), .rst(rst), .spike_in(spike_in), .in_valid(vb), .wr_en(web),
        .wr_neuron(wr_neuron), .wr_input(wr_input), .wr_data(wr_data),
        .neuron_rst(nr_b), .spike_out(spb), .refrac_busy(bzb));

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        chk++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    // drive one cycle and queue what the outputs must show after its edge
    task automatic cyc(input logic [3:0] s, input logic v, input logic [1:0] nr,
                       input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic b, input logic [1:0] esp, input logic [1:0] ebz,
                       input logic [15:0] e0, input logic [15:0] e1);
        exp_t e;
        @(negedge clk);
        spike_in = s;
        va = v & ~b;
        vb = v & b;
        nr_a = nr;
        wea = we & ~b;
        web = we & b;
        wr_neuron = wa[2];
        wr_input = wa[1:0];
        wr_data = wd;
        e.b = b; e.sp = esp; e.bz = ebz; e.p0 = e0; e.p1 = e1;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n++;
                check($sformatf("t%0d spike_out", n), 16'(e.b ? spb : spa), 16'(e.sp));
                check($sformatf("t%0d refrac_busy", n), 16'(e.b ? bzb : bza), 16'(e.bz));
                check($sformatf("t%0d pot0", n), e.b ? dut_b.pot[0] : dut_a.pot[0], e.p0);
                check($sformatf("t%0d pot1", n), e.b ? dut_b.pot[1] : dut_a.pot[1], e.p1);
            end
        end
    end

    initial begin
        #3;
        check("reset spike_out", 16'(spa), 16'd0);
        check("reset refrac_busy", 16'(bza), 16'd0);
        check("reset pot0", dut_a.pot[0], 16'd0);
        repeat (2) @(negedge clk);
        rst = 1;
        // s v nr we wa wd b | sp bz p0 p1
        cyc(4'h0, 0, 2'b00, 1, 3'd0, 8'd4, 0, 2'b00, 2'b00, 16'd0, 16'd0);
        cyc(4'h0, 0, 2'b00, 1, 3'd4, 8'd5, 0, 2'b00, 2'b00, 16'd0, 16'd0);
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b00, 2'b00, 16'd4, 16'd5);
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b10, 2'b10, 16'd8, 16'd0);
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b01, 2'b11, 16'd0, 16'd0);
        cyc(4'h0, 0, 2'b00, 0, 3'd0, 8'd0, 0, 2'b00, 2'b11, 16'd0, 16'd0);
        cyc(4'hF, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b00, 2'b01, 16'd0, 16'd0);
        cyc(4'hF, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b00, 2'b00, 16'd0, 16'd5);
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b10, 2'b10, 16'd4, 16'd0);
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b00, 2'b10, 16'd8, 16'd0);
        cyc(4'h1, 1, 2'b01, 0, 3'd0, 8'd0, 0, 2'b00, 2'b00, 16'd0, 16'd0);
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b00, 2'b00, 16'd4, 16'd5);
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b10, 2'b10, 16'd8, 16'd0);
        cyc(4'h1, 1, 2'b10, 0, 3'd0, 8'd0, 0, 2'b01, 2'b11, 16'd0, 16'd0);
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b00, 2'b11, 16'd0, 16'd0);
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b00, 2'b00, 16'd0, 16'd0);
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b00, 2'b00, 16'd4, 16'd5);
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b10, 2'b10, 16'd8, 16'd0);
        // neuron 1 is mid-spike and refractory here; reset with in_valid still high
        @(negedge clk);
        rst = 0;
        #1;
        check("async rst spike_out", 16'(spa), 16'd0);
        check("async rst refrac_busy", 16'(bza), 16'd0);
        check("async rst pot1", dut_a.pot[1], 16'd0);
        check("async rst w00", 16'(dut_a.w[0][0]), 16'd0);
        check("async rst w10", 16'(dut_a.w[1][0]), 16'd0);
        @(posedge clk);
        #1;
        check("held rst spike_out", 16'(spa), 16'd0);
        check("held rst refrac_busy", 16'(bza), 16'd0);
        @(negedge clk);
        rst = 1;
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b00, 2'b00, 16'd0, 16'd0);
        cyc(4'h1, 1, 2'b00, 1, 3'd0, 8'd9, 0, 2'b00, 2'b00, 16'd0, 16'd0);
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b00, 2'b00, 16'd9, 16'd0);
        cyc(4'h1, 1, 2'b00, 0, 3'd0, 8'd0, 0, 2'b01, 2'b01, 16'd0, 16'd0);
        cyc(4'h0, 0, 2'b00, 0, 3'd0, 8'd0, 0, 2'b00, 2'b01, 16'd0, 16'd0);
        for (int a = 0; a < 8; a++)
            cyc(4'h0, 0, 2'b00, 1, 3'(a), 8'd255, 1, 2'b00, 2'b00, 16'd0, 16'd0);
        for (int k = 1; k <= 64; k++)
            cyc(4'hF, 1, 2'b00, 0, 3'd0, 8'd0, 1, 2'b00, 2'b00, 16'(1020 * k), 16'(1020 * k));
        cyc(4'hF, 1, 2'b00, 0, 3'd0, 8'd0, 1, 2'b11, 2'b11, 16'd0, 16'd0);
        cyc(4'h0, 0, 2'b00, 0, 3'd0, 8'd0, 1, 2'b00, 2'b11, 16'd0, 16'd0);
        repeat (4) @(posedge clk);
        #2;
        check("scoreboard drained", 16'(q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
